fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Owns the instruction memory's single address port and controls all access to it. It loads programs over a byte stream, writing them into memory from address 0. It then runs the fetch loop: it drives the PC, registers each instruction toward decode, and handles stall, branch redirect and halt. Only one user, either the loader or fetch, drives the memory at a time, so the memory needs no second port.

## Interface
- PC_WIDTH, 8, width of PC and memory address (256-word program space)
- INSTRUCTION_WIDTH, 16, instruction width; must be a multiple of 8
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- load_start  in  1  pulse in IDLE: begin program load
- load_length  in  PC_WIDTH+1  number of words to load, sampled with load_start
- load_valid / load_ready  in / out  1 / 1  byte-stream handshake
- load_byte  in  8  program byte, MSB-first within each word
- load_done  out  1  one-cycle pulse when a load completes
- run  in  1  pulse in IDLE: start execution at PC 0
- stall  in  1  decode back-pressure: hold PC and fetch register
- branch_valid  in  1  redirect request from execute
- branch_target  in  PC_WIDTH  redirect address
- halt_req  in  1  stop execution, return to IDLE
- mem_addr  out  PC_WIDTH  address to the instruction memory (combinational read)
- mem_rdata  in  INSTRUCTION_WIDTH  memory read data
- mem_we  out  1  memory write strobe
- mem_wdata  out  INSTRUCTION_WIDTH  memory write data
- fetch_valid  out  1  fetch_instruction / fetch_pc are valid
- fetch_pc  out  PC_WIDTH  address of fetch_instruction
- fetch_instruction  out  INSTRUCTION_WIDTH  registered instruction
- running  out  1  high in RUN

## Operation
- States: IDLE, LOAD, WRITE, RUN. Reset enters IDLE.
- IDLE:
  - load_start moves to LOAD, clears load_addr and the byte counter, and latches load_length.
  - If load_length = 0, it stays in IDLE and pulses load_done on the next cycle.
  - run moves to RUN with pc = 0.
  - If load_start and run arrive together, the load wins and run is ignored.
  - load_start and run are ignored in every other state.
- LOAD:
  - load_ready = 1.
  - Each accepted byte (load_valid & load_ready) shifts into the assembly register from the LSB side, so the first byte ends up as the MSB.
  - After INSTRUCTION_WIDTH/8 bytes, the state moves to WRITE.
- WRITE: one cycle, load_ready = 0, mem_we = 1, mem_addr = load_addr, mem_wdata = assembled word. Then load_addr increments.
  - If the words written equal load_length, the state moves to IDLE and load_done pulses in the same cycle as the transition edge (visible the first IDLE cycle).
  - Otherwise the state returns to LOAD.
- RUN: mem_addr = pc. Priority on each edge is halt_req > branch_valid > stall > normal.
  - halt_req: go to IDLE, fetch_valid <= 0.
  - branch_valid: pc <= branch_target, fetch_valid <= 0. This flushes the wrong-path slot and applies even if stall is high.
  - stall: pc, fetch_* hold.
  - normal: fetch_instruction <= mem_rdata, fetch_pc <= pc, fetch_valid <= 1, pc <= pc + 1 modulo 2^PC_WIDTH. After 255 the PC wraps to 0 with no flag.
- Outside RUN, mem_addr = load_addr and fetch_valid = 0.
- mem_we is high only in WRITE.

## Timing
- Reset values:
  - state IDLE; pc, load_addr, byte counter 0
  - fetch_valid, fetch_pc, fetch_instruction 0
  - load_ready, load_done, mem_we, running 0
  - mem_addr 0, mem_wdata 0
- Reset mid-load or mid-run aborts immediately. Memory contents already written are kept, and no load_done is issued.
- Fetch latency: an instruction at address A appears on fetch_* one cycle after the cycle in which pc = A.
- Throughput is one instruction per cycle with no stall.
- Branch penalty is one bubble: the cycle after branch_valid has fetch_valid = 0, and the target instruction appears the cycle after that.
- Load costs INSTRUCTION_WIDTH/8 + 1 cycles per word at full rate. With a 16-bit word that is 3 cycles/word, so 256 words take 768 cycles plus 1 for load_done.
- load_valid may toggle freely. A byte counts only on a cycle where load_valid & load_ready.
- load_length > 2^PC_WIDTH is clamped to 2^PC_WIDTH.

## Test plan
- Load and run:
  - Stimulus: reset, load_start with load_length = 3, stream bytes 12 34 AB CD 00 FF at full rate.
  - Response: writes 0x1234 @0, 0xABCD @1, 0x00FF @2, with mem_we high exactly 3 cycles; load_done pulses once.
  - Then run: fetch sequence (0,1234), (1,ABCD), (2,00FF) on consecutive cycles.
- Gapped stream:
  - Stimulus: load_valid low on alternate cycles.
  - Response: same memory contents; no byte is lost or duplicated.
- Branch:
  - Stimulus: in RUN with pc = 5, assert branch_valid with target 0x40, stall also high.
  - Response: next cycle fetch_valid = 0; the following cycle fetch_pc = 0x40.
- Stall hold:
  - Stimulus: stall for 4 cycles.
  - Response: fetch_* and pc are constant; resuming gives the next sequential PC with no skip.
- Edge cases:
  - PC at 0xFF wraps to 0x00.
  - load_length = 0 gives load_done with no mem_we.
  - run and load_start together enter LOAD.
  - halt_req together with branch_valid goes to IDLE.
- Reset mid-load:
  - Stimulus: reset after 1.5 words.
  - Response: all outputs at reset values, word 0 retained, no load_done.
  - A subsequent load starts at address 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sole owner of the instruction memory's single address port.
// Loads a program from a byte stream (MSB-first per word, starting at address 0)
// and then runs the fetch loop with stall, branch redirect and halt handling.
module fetch_sequencer #(
    parameter int PC_WIDTH          = 8,
    parameter int INSTRUCTION_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         load_start,
    input  logic [PC_WIDTH:0]            load_length,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [7:0]                   load_byte,
    output logic                         load_done,
    input  logic                         run,
    input  logic                         stall,
    input  logic                         branch_valid,
    input  logic [PC_WIDTH-1:0]          branch_target,
    input  logic                         halt_req,
    output logic [PC_WIDTH-1:0]          mem_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata,
    output logic                         mem_we,
    output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
    output logic                         fetch_valid,
    output logic [PC_WIDTH-1:0]          fetch_pc,
    output logic [INSTRUCTION_WIDTH-1:0] fetch_instruction,
    output logic                         running
);

    localparam int BYTES  = INSTRUCTION_WIDTH / 8;
    localparam int BCNT_W = $clog2(BYTES + 1);
    localparam logic [BCNT_W-1:0]   LAST_BYTE = BCNT_W'(BYTES - 1);
    localparam logic [PC_WIDTH:0]   MAX_LEN   = {1'b1, {PC_WIDTH{1'b0}}};
    localparam logic [PC_WIDTH:0]   LEN_ONE   = (PC_WIDTH + 1)'(1);
    localparam logic [PC_WIDTH-1:0] PC_ONE    = PC_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [PC_WIDTH-1:0]            pc_q, pc_d;
    logic [PC_WIDTH-1:0]            load_addr_q, load_addr_d;
    logic [BCNT_W-1:0]              bcnt_q, bcnt_d;
    logic [PC_WIDTH:0]              len_q, len_d;
    logic [INSTRUCTION_WIDTH-1:0]   asm_q, asm_d;
    logic                           fv_q, fv_d;
    logic [PC_WIDTH-1:0]            fpc_q, fpc_d;
    logic [INSTRUCTION_WIDTH-1:0]   finstr_q, finstr_d;
    logic                           load_done_q, load_done_d;
    logic                           load_ready_q, load_ready_d;
    logic                           mem_we_q, mem_we_d;
    logic                           running_q, running_d;

    // Lengths beyond the program space can never be written; cap them so the
    // word-count comparison still terminates the load.
    function automatic logic [PC_WIDTH:0] clamp_len(input logic [PC_WIDTH:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    // Next-state logic for the loader/fetch FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        load_addr_d = load_addr_q;
        bcnt_d      = bcnt_q;
        len_d       = len_q;
        asm_d       = asm_q;
        fv_d        = fv_q;
        fpc_d       = fpc_q;
        finstr_d    = finstr_q;
        load_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                // A load request takes precedence over a simultaneous run.
                if (load_start) begin
                    load_addr_d = '0;
                    bcnt_d      = '0;
                    len_d       = clamp_len(load_length);
                    if (load_length == '0) begin
                        load_done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end else if (run) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            LOAD: begin
                if (load_valid && load_ready_q) begin
                    asm_d = (asm_q << 8) | INSTRUCTION_WIDTH'(load_byte);
                    if (bcnt_q == LAST_BYTE) begin
                        bcnt_d  = '0;
                        state_d = WRITE;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end
            end
            WRITE: begin
                load_addr_d = load_addr_q + PC_ONE;
                if (({1'b0, load_addr_q} + LEN_ONE) == len_q) begin
                    state_d     = IDLE;
                    load_done_d = 1'b1;
                end else begin
                    state_d = LOAD;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_d = IDLE;
                    fv_d    = 1'b0;
                end else if (branch_valid) begin
                    // Redirect overrides stall and squashes the wrong-path slot.
                    pc_d = branch_target;
                    fv_d = 1'b0;
                end else if (!stall) begin
                    finstr_d = mem_rdata;
                    fpc_d    = pc_q;
                    fv_d     = 1'b1;
                    pc_d     = pc_q + PC_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        load_ready_d = (state_d == LOAD);
        mem_we_d     = (state_d == WRITE);
        running_d    = (state_d == RUN);
    end

    // State and registered outputs; reset aborts any load or run in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            load_addr_q  <= '0;
            bcnt_q       <= '0;
            len_q        <= '0;
            asm_q        <= '0;
            fv_q         <= 1'b0;
            fpc_q        <= '0;
            finstr_q     <= '0;
            load_done_q  <= 1'b0;
            load_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            load_addr_q  <= load_addr_d;
            bcnt_q       <= bcnt_d;
            len_q        <= len_d;
            asm_q        <= asm_d;
            fv_q         <= fv_d;
            fpc_q        <= fpc_d;
            finstr_q     <= finstr_d;
            load_done_q  <= load_done_d;
            load_ready_q <= load_ready_d;
            mem_we_q     <= mem_we_d;
            running_q    <= running_d;
        end
    end

    // The single memory port follows the PC in RUN and the load address otherwise.
    assign mem_addr          = (state_q == RUN) ? pc_q : load_addr_q;
    assign mem_wdata         = asm_q;
    assign mem_we            = mem_we_q;
    assign load_ready        = load_ready_q;
    assign load_done         = load_done_q;
    assign running           = running_q;
    assign fetch_valid       = fv_q;
    assign fetch_pc          = fpc_q;
    assign fetch_instruction = finstr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a behavioural instruction memory,
// a write scoreboard for the loader and a per-cycle fetch scoreboard.
module tb_fetch_sequencer;

    localparam int PW = 8;
    localparam int IW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          load_start;
    logic [PW:0]   load_length;
    logic          load_valid;
    logic          load_ready;
    logic [7:0]    load_byte;
    logic          load_done;
    logic          run;
    logic          stall;
    logic          branch_valid;
    logic [PW-1:0] branch_target;
    logic          halt_req;
    logic [PW-1:0] mem_addr;
    logic [IW-1:0] mem_rdata;
    logic          mem_we;
    logic [IW-1:0] mem_wdata;
    logic          fetch_valid;
    logic [PW-1:0] fetch_pc;
    logic [IW-1:0] fetch_instruction;
    logic          running;

    always #5 clock = ~clock;

    fetch_sequencer #(.PC_WIDTH(PW), .INSTRUCTION_WIDTH(IW)) dut (
        .clock(clock), .reset(reset),
        .load_start(load_start), .load_length(load_length),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_byte(load_byte), .load_done(load_done),
        .run(run), .stall(stall),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .halt_req(halt_req),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_instruction(fetch_instruction), .running(running)
    );

    // Instruction memory: combinational read, written by the DUT or by preload.
    logic [IW-1:0] mem [256];
    logic          pre_we;
    logic [7:0]    pre_addr;
    logic [IW-1:0] pre_data;

    always @(posedge clock) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    int errors = 0;
    int checks = 0;

    // Bench expectation of memory contents and of the fetch stage.
    logic [IW-1:0] model [256];
    bit            m_run;
    logic [7:0]    m_pc;
    bit            m_fv;
    logic [7:0]    m_fpc;
    logic [IW-1:0] m_finstr;

    typedef struct packed {
        logic          fv;
        logic [7:0]    fpc;
        logic [IW-1:0] finstr;
        logic          run;
        logic [7:0]    pc;
    } fexp_t;
    fexp_t fq[$];

    typedef struct packed {
        logic [7:0]    a;
        logic [IW-1:0] d;
    } wexp_t;
    wexp_t wq[$];

    logic [IW-1:0] words[$];

    task automatic model_reset();
        m_run = 0; m_pc = '0; m_fv = 0; m_fpc = '0; m_finstr = '0;
        fq.delete();
    endtask

    // One fetch-loop cycle: drive controls, predict next outputs, compare.
    task automatic sb_cycle(input bit r, input bit h, input bit b,
                            input logic [7:0] t, input bit s);
        fexp_t e;
        run = r; halt_req = h; branch_valid = b; branch_target = t; stall = s;
        if (m_run) begin
            if (h) begin
                m_run = 0; m_fv = 0;
            end else if (b) begin
                m_pc = t; m_fv = 0;
            end else if (!s) begin
                m_fpc = m_pc; m_finstr = model[m_pc]; m_fv = 1; m_pc = m_pc + 8'd1;
            end
        end else if (r) begin
            m_run = 1; m_pc = '0;
        end
        e.fv = m_fv; e.fpc = m_fpc; e.finstr = m_finstr; e.run = m_run; e.pc = m_pc;
        fq.push_back(e);
        @(negedge clock);
        e = fq.pop_front();
        checks++;
        if (fetch_valid !== e.fv) begin
            errors++; $display("FAIL fetch_valid: got %b expected %b", fetch_valid, e.fv);
        end
        if (e.fv) begin
            checks++;
            if (fetch_pc !== e.fpc || fetch_instruction !== e.finstr) begin
                errors++;
                $display("FAIL fetch_data: got (%h,%h) expected (%h,%h)",
                         fetch_pc, fetch_instruction, e.fpc, e.finstr);
            end
        end
        checks++;
        if (running !== e.run) begin
            errors++; $display("FAIL running: got %b expected %b", running, e.run);
        end
        if (e.run) begin
            checks++;
            if (mem_addr !== e.pc) begin
                errors++; $display("FAIL pc: got %h expected %h", mem_addr, e.pc);
            end
        end
        run = 0; halt_req = 0; branch_valid = 0; stall = 0;
    endtask

    // Stream words[0..len-1] in and check every write and the done pulse.
    task automatic run_load(input int len, input bit gapped, input bit with_run);
        int n;
        int bi;
        int we_cnt;
        int done_cnt;
        int cyc;
        int post;
        logic [7:0] bytes[$];
        wexp_t w;
        n = (len > 256) ? 256 : len;
        wq.delete();
        for (int i = 0; i < n; i++) begin
            bytes.push_back(words[i][15:8]);
            bytes.push_back(words[i][7:0]);
            w.a = i[7:0]; w.d = words[i];
            wq.push_back(w);
            model[i] = words[i];
        end
        bi = 0; we_cnt = 0; done_cnt = 0; cyc = 0; post = -1;
        load_start = 1; load_length = 9'(len); run = with_run; load_valid = 0;
        while (cyc < 3 * n + 20 && post != 0) begin
            @(negedge clock);
            cyc++;
            load_start = 0; run = 0;
            if (mem_we) begin
                we_cnt++;
                checks++;
                if (wq.size() == 0) begin
                    errors++; $display("FAIL extra_write: addr %h data %h, none expected", mem_addr, mem_wdata);
                end else begin
                    w = wq.pop_front();
                    if (mem_addr !== w.a || mem_wdata !== w.d) begin
                        errors++;
                        $display("FAIL mem_write: got %h@%h expected %h@%h", mem_wdata, mem_addr, w.d, w.a);
                    end
                end
            end
            if (post > 0) post--;
            if (load_done) begin
                done_cnt++;
                if (post < 0) post = 3;
            end
            checks++;
            if (running !== 1'b0) begin
                errors++; $display("FAIL running_in_load: got %b expected 0", running);
            end
            if (bi < bytes.size()) begin
                load_byte = bytes[bi];
                load_valid = gapped ? ((cyc % 2) == 1) : 1'b1;
                if (load_valid && load_ready) bi++;
            end else begin
                load_valid = 0;
            end
        end
        load_valid = 0;
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL load_done_count: got %0d expected 1 (0 means timeout)", done_cnt);
        end
        checks++;
        if (we_cnt != n) begin
            errors++; $display("FAIL mem_we_cycles: got %0d expected %0d", we_cnt, n);
        end
        checks++;
        if (bi != bytes.size() || wq.size() != 0) begin
            errors++; $display("FAIL load_progress: bytes %0d of %0d, writes pending %0d expected 0",
                               bi, bytes.size(), wq.size());
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(negedge clock);
        checks++;
        if ({fetch_valid, fetch_pc, fetch_instruction} !== '0) begin
            errors++; $display("FAIL reset_fetch: got %b/%h/%h expected 0", fetch_valid, fetch_pc, fetch_instruction);
        end
        checks++;
        if ({load_ready, load_done, mem_we, running} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {load_ready, load_done, mem_we, running});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++; $display("FAIL reset_mem: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
        end
        reset = 0;
        model_reset();
    endtask

    task automatic test_load_run();
        words = '{16'h1234, 16'hABCD, 16'h00FF};
        run_load(3, 0, 0);
        sb_cycle(1, 0, 0, 8'h00, 0);
        repeat (3) sb_cycle(0, 0, 0, 8'h00, 0);
        sb_cycle(0, 1, 0, 8'h00, 0);
    endtask

    task automatic test_gapped();
        words = '{16'h1234, 16'hABCD, 16'h00FF};
        run_load(3, 1, 0);
        sb_cycle(1, 0, 0, 8'h00, 0);
        repeat (3) sb_cycle(0, 0, 0, 8'h00, 0);
        sb_cycle(0, 1, 0, 8'h00, 0);
    endtask

    task automatic test_branch();
        sb_cycle(1, 0, 0, 8'h00, 0);
        repeat (5) sb_cycle(0, 0, 0, 8'h00, 0);
        sb_cycle(0, 0, 1, 8'h40, 1);
        repeat (3) sb_cycle(0, 0, 0, 8'h00, 0);
        sb_cycle(0, 1, 0, 8'h00, 0);
    endtask

    task automatic test_stall();
        sb_cycle(1, 0, 0, 8'h00, 0);
        repeat (3) sb_cycle(0, 0, 0, 8'h00, 0);
        repeat (4) sb_cycle(0, 0, 0, 8'h00, 1);
        repeat (3) sb_cycle(0, 0, 0, 8'h00, 0);
        sb_cycle(0, 1, 0, 8'h00, 0);
    endtask

    task automatic test_wrap();
        sb_cycle(1, 0, 0, 8'h00, 0);
        sb_cycle(0, 0, 1, 8'hFE, 0);
        repeat (5) sb_cycle(0, 0, 0, 8'h00, 0);
        sb_cycle(0, 1, 0, 8'h00, 0);
    endtask

    task automatic test_zero_len();
        words.delete();
        run_load(0, 0, 0);
    endtask

    task automatic test_run_and_load();
        words = '{16'h7E81};
        run_load(1, 0, 1);
        sb_cycle(0, 0, 0, 8'h00, 0);
    endtask

    task automatic test_halt_branch();
        sb_cycle(1, 0, 0, 8'h00, 0);
        repeat (2) sb_cycle(0, 0, 0, 8'h00, 0);
        sb_cycle(0, 1, 1, 8'h20, 0);
        repeat (2) sb_cycle(0, 0, 0, 8'h00, 0);
    endtask

    task automatic test_reset_midload();
        logic [7:0] bytes[$];
        wexp_t w;
        int acc;
        int cyc;
        bit abort;
        bytes = '{8'hBE, 8'hEF, 8'hCA, 8'hFE};
        wq.delete();
        w.a = 8'h00; w.d = 16'hBEEF;
        wq.push_back(w);
        model[0] = 16'hBEEF;
        acc = 0; cyc = 0; abort = 0;
        load_start = 1; load_length = 9'd2; load_valid = 0;
        while (!abort && cyc < 20) begin
            @(negedge clock);
            cyc++;
            load_start = 0;
            if (mem_we) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++; $display("FAIL abort_extra_write: %h@%h", mem_wdata, mem_addr);
                end else begin
                    w = wq.pop_front();
                    if (mem_addr !== w.a || mem_wdata !== w.d) begin
                        errors++; $display("FAIL abort_write: got %h@%h expected %h@%h", mem_wdata, mem_addr, w.d, w.a);
                    end
                end
            end
            checks++;
            if (load_done !== 1'b0) begin
                errors++; $display("FAIL abort_load_done: got %b expected 0", load_done);
            end
            if (acc == 3) begin
                reset = 1; load_valid = 0; abort = 1;
            end else begin
                load_byte = bytes[acc]; load_valid = 1;
                if (load_ready) acc++;
            end
        end
        checks++;
        if (!abort) begin
            errors++; $display("FAIL abort_timeout: accepted %0d bytes expected 3", acc);
        end
        @(negedge clock);
        checks++;
        if ({fetch_valid, fetch_pc, fetch_instruction} !== '0) begin
            errors++; $display("FAIL abort_fetch: got %b/%h/%h expected 0", fetch_valid, fetch_pc, fetch_instruction);
        end
        checks++;
        if ({load_ready, load_done, mem_we, running} !== 4'b0) begin
            errors++; $display("FAIL abort_ctrl: got %b expected 0000", {load_ready, load_done, mem_we, running});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || wq.size() != 0) begin
            errors++; $display("FAIL abort_mem: addr %h wdata %h pending %0d expected 0/0/0", mem_addr, mem_wdata, wq.size());
        end
        reset = 0;
        model_reset();
        @(negedge clock);
        checks++;
        if (load_done !== 1'b0) begin
            errors++; $display("FAIL abort_late_done: got %b expected 0", load_done);
        end
        sb_cycle(1, 0, 0, 8'h00, 0);
        repeat (2) sb_cycle(0, 0, 0, 8'h00, 0);
        sb_cycle(0, 1, 0, 8'h00, 0);
        words = '{16'h1357};
        run_load(1, 0, 0);
    endtask

    initial begin
        reset = 1; load_start = 0; load_length = '0; load_valid = 0; load_byte = '0;
        run = 0; stall = 0; branch_valid = 0; branch_target = '0; halt_req = 0;
        pre_we = 0; pre_addr = '0; pre_data = '0;
        model_reset();
        for (int i = 0; i < 256; i++) begin
            pre_we = 1; pre_addr = i[7:0]; pre_data = {i[7:0] ^ 8'hC3, i[7:0]};
            model[i] = {i[7:0] ^ 8'hC3, i[7:0]};
            @(negedge clock);
        end
        pre_we = 0;
        test_reset();
        test_load_run();
        test_gapped();
        test_branch();
        test_stall();
        test_wrap();
        test_zero_len();
        test_run_and_load();
        test_halt_branch();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
